// File: rtl/l2_coherence_requester.sv
// L2-side MESI coherence requester: queues L2 lookups/notifies, drives the
// arbiter strobe/ack handshake and returns the resolved state upstream.
module l2_coherence_requester #(
   parameter int FIFO_DEPTH             = 4,
   parameter int TIMEOUT_CYCLES         = 64,
   parameter int ADDRESS_WIDTH          = 32,
   parameter int MAIN_MEMORY_DATA_WIDTH = 32,
   parameter int MESI_STATE_WIDTH       = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              req_valid,
   input  logic                              req_is_write,
   input  logic [ADDRESS_WIDTH-1:0]          req_addr,
   input  logic [MAIN_MEMORY_DATA_WIDTH-1:0] req_data,
   output logic                              req_ready,
   output logic [ADDRESS_WIDTH-1:0]          block_to_determine_mesi_state_from_arbiter,
   output logic [MAIN_MEMORY_DATA_WIDTH-1:0] local_data,
   output logic                              arbiter_read_update_from_L2_cache_modules,
   output logic                              arbiter_write_update_from_L2_cache_modules,
   output logic                              acknowledge_arbiter_verify,
   input  logic [MESI_STATE_WIDTH-1:0]       mesi_state_to_cache,
   input  logic                              arbiter_verify,
   output logic                              rsp_valid,
   output logic [MESI_STATE_WIDTH-1:0]       rsp_mesi_state,
   output logic [ADDRESS_WIDTH-1:0]          rsp_addr,
   output logic                              rsp_timeout
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, REQ, ACK, RESP} state_t;

   state_t                            state;
   logic [ADDRESS_WIDTH-1:0]          fifo_addr [FIFO_DEPTH];
   logic [MAIN_MEMORY_DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic                              fifo_wr   [FIFO_DEPTH];
   logic [PW-1:0]                     wr_ptr;
   logic [PW-1:0]                     rd_ptr;
   logic [CW-1:0]                     count;
   logic [TW-1:0]                     tmo_cnt;
   logic [MESI_STATE_WIDTH-1:0]       cap_state;
   logic                              push;
   logic                              pop;

   assign req_ready = (count != FULL_CNT);
   assign push      = req_valid && req_ready;
   assign pop       = (state == IDLE) && (count != '0);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= req_addr;
         fifo_data[wr_ptr] <= req_data;
         fifo_wr[wr_ptr]   <= req_is_write;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         tmo_cnt    <= '0;
         cap_state  <= '0;
         block_to_determine_mesi_state_from_arbiter <= '0;
         local_data <= '0;
         arbiter_read_update_from_L2_cache_modules  <= 1'b0;
         arbiter_write_update_from_L2_cache_modules <= 1'b0;
         acknowledge_arbiter_verify <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_mesi_state <= '0;
         rsp_addr       <= '0;
         rsp_timeout    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (pop) begin
                  block_to_determine_mesi_state_from_arbiter <= fifo_addr[rd_ptr];
                  local_data <= fifo_data[rd_ptr];
                  arbiter_write_update_from_L2_cache_modules <= fifo_wr[rd_ptr];
                  arbiter_read_update_from_L2_cache_modules  <= !fifo_wr[rd_ptr];
                  tmo_cnt <= '0;
                  state   <= REQ;
               end
            end
            REQ: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               // a verify landing on the last cycle still wins over the abort
               if (arbiter_verify) begin
                  cap_state <= mesi_state_to_cache;
                  arbiter_read_update_from_L2_cache_modules  <= 1'b0;
                  arbiter_write_update_from_L2_cache_modules <= 1'b0;
                  acknowledge_arbiter_verify <= 1'b1;
                  state <= ACK;
               end else if (tmo_cnt == TMO_LAST) begin
                  arbiter_read_update_from_L2_cache_modules  <= 1'b0;
                  arbiter_write_update_from_L2_cache_modules <= 1'b0;
                  rsp_valid      <= 1'b1;
                  rsp_timeout    <= 1'b1;
                  rsp_mesi_state <= '0;
                  rsp_addr <= block_to_determine_mesi_state_from_arbiter;
                  state    <= RESP;
               end
            end
            ACK: begin
               if (!arbiter_verify) begin
                  acknowledge_arbiter_verify <= 1'b0;
                  rsp_valid      <= 1'b1;
                  rsp_timeout    <= 1'b0;
                  rsp_mesi_state <= cap_state;
                  rsp_addr <= block_to_determine_mesi_state_from_arbiter;
                  state    <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_coherence_requester.sv
// Directed bench for l2_coherence_requester: handshake, queueing, timeout,
// ack hold and mid-transaction reset.
module tb_l2_coherence_requester;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_is_write;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        req_ready;
   logic [31:0] blk_addr;
   logic [31:0] local_data;
   logic        rd_s;
   logic        wr_s;
   logic        ack;
   logic [1:0]  mesi_in;
   logic        verify;
   logic        rsp_valid;
   logic [1:0]  rsp_state;
   logic [31:0] rsp_addr;
   logic        rsp_timeout;

   int n_cmp = 0;
   int n_err = 0;
   int viol  = 0;

   always #5 clk = ~clk;

   l2_coherence_requester dut (
      .clk                                        (clk),
      .reset                                      (reset),
      .req_valid                                  (req_valid),
      .req_is_write                               (req_is_write),
      .req_addr                                   (req_addr),
      .req_data                                   (req_data),
      .req_ready                                  (req_ready),
      .block_to_determine_mesi_state_from_arbiter (blk_addr),
      .local_data                                 (local_data),
      .arbiter_read_update_from_L2_cache_modules  (rd_s),
      .arbiter_write_update_from_L2_cache_modules (wr_s),
      .acknowledge_arbiter_verify                 (ack),
      .mesi_state_to_cache                        (mesi_in),
      .arbiter_verify                             (verify),
      .rsp_valid                                  (rsp_valid),
      .rsp_mesi_state                             (rsp_state),
      .rsp_addr                                   (rsp_addr),
      .rsp_timeout                                (rsp_timeout)
   );

   // handshake invariants watched continuously
   always @(negedge clk) begin
      if ((rd_s && wr_s) || ((rd_s || wr_s) && ack)) viol++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; req_valid = 1'b0; req_is_write = 1'b0;
      req_addr = '0; req_data = '0; mesi_in = '0; verify = 1'b0;
      step; step;
      reset = 1'b0;
      n_cmp++;
      if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", req_ready); end
      n_cmp++;
      if ({rd_s, wr_s, ack, rsp_valid, rsp_timeout} !== 5'b0) begin
         n_err++; $display("FAIL reset_ctl got %b want 00000", {rd_s, wr_s, ack, rsp_valid, rsp_timeout});
      end
      n_cmp++;
      if ({blk_addr, local_data, rsp_addr, rsp_state} !== 98'b0) begin
         n_err++; $display("FAIL reset_data got %h want 0", {blk_addr, local_data, rsp_addr, rsp_state});
      end
   endtask

   task automatic test_read;
      req_valid = 1'b1; req_is_write = 1'b0; req_addr = 32'h40; req_data = 32'h1111;
      step;
      req_valid = 1'b0;
      n_cmp++;
      if ({rd_s, wr_s} !== 2'b00) begin n_err++; $display("FAIL rd_early got %b want 00", {rd_s, wr_s}); end
      step;
      n_cmp++;
      if ({rd_s, wr_s, ack} !== 3'b100 || blk_addr !== 32'h40) begin
         n_err++; $display("FAIL rd_strobe got %b addr %h want 100 addr 40", {rd_s, wr_s, ack}, blk_addr);
      end
      verify = 1'b1; mesi_in = 2'b10;
      step;
      verify = 1'b0;
      n_cmp++;
      if ({rd_s, ack, rsp_valid} !== 3'b010) begin
         n_err++; $display("FAIL rd_ack got %b want 010", {rd_s, ack, rsp_valid});
      end
      step;
      n_cmp++;
      if ({ack, rsp_valid, rsp_timeout} !== 3'b010 || rsp_state !== 2'b10 || rsp_addr !== 32'h40) begin
         n_err++; $display("FAIL rd_rsp got v%b st %b a %h want v010 st 10 a 40",
                           {ack, rsp_valid, rsp_timeout}, rsp_state, rsp_addr);
      end
      step;
      n_cmp++;
      if (rsp_valid !== 1'b0 || rsp_state !== 2'b10) begin
         n_err++; $display("FAIL rd_rsp_pulse got v%b st %b want v0 st 10", rsp_valid, rsp_state);
      end
   endtask

   task automatic test_write;
      req_valid = 1'b1; req_is_write = 1'b1; req_addr = 32'h80; req_data = 32'hDEADBEEF;
      step;
      req_valid = 1'b0;
      step;
      n_cmp++;
      if ({rd_s, wr_s} !== 2'b01 || local_data !== 32'hDEADBEEF || blk_addr !== 32'h80) begin
         n_err++; $display("FAIL wr_strobe got %b d %h a %h want 01 d deadbeef a 80",
                           {rd_s, wr_s}, local_data, blk_addr);
      end
      verify = 1'b1; mesi_in = 2'b11;
      step;
      verify = 1'b0;
      n_cmp++;
      if ({wr_s, ack} !== 2'b01) begin n_err++; $display("FAIL wr_ack got %b want 01", {wr_s, ack}); end
      step;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_state !== 2'b11 || rsp_addr !== 32'h80 || rsp_timeout !== 1'b0) begin
         n_err++; $display("FAIL wr_rsp got v%b st %b a %h t%b want v1 st 11 a 80 t0",
                           rsp_valid, rsp_state, rsp_addr, rsp_timeout);
      end
      step;
   endtask

   task automatic test_back_to_back;
      int rise [2];
      int nr;
      nr = 0; rise[0] = -1; rise[1] = -1;
      req_valid = 1'b1; req_is_write = 1'b0; req_addr = 32'h200;
      step;
      req_addr = 32'h240;
      step;
      req_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (rd_s) begin
            if (nr < 2) rise[nr] = i;
            nr++;
            verify = 1'b1; mesi_in = 2'b01;
         end else begin
            verify = 1'b0;
         end
         step;
      end
      verify = 1'b0;
      n_cmp++;
      if (nr !== 2 || rise[0] !== 0 || rise[1] !== 4) begin
         n_err++; $display("FAIL b2b_spacing got n%0d r0 %0d r1 %0d want n2 r0 0 r1 4", nr, rise[0], rise[1]);
      end
   endtask

   task automatic test_fifo_full;
      logic [31:0] exp_a [5];
      logic [1:0]  exp_m [5];
      int w;
      int extra;
      exp_a = '{32'h1000, 32'h1100, 32'h1200, 32'h1300, 32'h1400};
      exp_m = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b01};
      verify = 1'b0;
      req_is_write = 1'b0;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; req_addr = exp_a[i];
         if (i == 4) begin
            n_cmp++;
            if (req_ready !== 1'b1) begin n_err++; $display("FAIL fifo_ready3 got %b want 1", req_ready); end
         end
         step;
      end
      n_cmp++;
      if (req_ready !== 1'b0) begin n_err++; $display("FAIL fifo_full got %b want 0", req_ready); end
      req_addr = 32'h1500;
      step;
      req_valid = 1'b0;
      n_cmp++;
      if (req_ready !== 1'b0) begin n_err++; $display("FAIL fifo_full_hold got %b want 0", req_ready); end
      for (int i = 0; i < 5; i++) begin
         w = 0;
         while (!(rd_s || wr_s) && w < 10) begin step; w++; end
         n_cmp++;
         if (w == 10 || blk_addr !== exp_a[i]) begin
            n_err++; $display("FAIL fifo_req%0d got a %h wait %0d want a %h", i, blk_addr, w, exp_a[i]);
         end
         verify = 1'b1; mesi_in = exp_m[i];
         step;
         verify = 1'b0;
         step;
         n_cmp++;
         if (rsp_valid !== 1'b1 || rsp_addr !== exp_a[i] || rsp_state !== exp_m[i]) begin
            n_err++; $display("FAIL fifo_rsp%0d got v%b a %h st %b want v1 a %h st %b",
                              i, rsp_valid, rsp_addr, rsp_state, exp_a[i], exp_m[i]);
         end
         step;
      end
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         if (rd_s || wr_s || rsp_valid) extra++;
         step;
      end
      n_cmp++;
      if (extra !== 0) begin n_err++; $display("FAIL fifo_drop got %0d extra cycles want 0", extra); end
   endtask

   task automatic test_timeout;
      int n;
      verify = 1'b0;
      req_valid = 1'b1; req_is_write = 1'b0; req_addr = 32'h3000;
      step;
      req_valid = 1'b0;
      step;
      n = 0;
      while ((rd_s || wr_s) && n < 100) begin n++; step; end
      n_cmp++;
      if (n !== 64) begin n_err++; $display("FAIL tmo_len got %0d want 64", n); end
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_state !== 2'b00 || rsp_addr !== 32'h3000) begin
         n_err++; $display("FAIL tmo_rsp got v%b t%b st %b a %h want v1 t1 st 00 a 3000",
                           rsp_valid, rsp_timeout, rsp_state, rsp_addr);
      end
      step;
      req_valid = 1'b1; req_is_write = 1'b1; req_addr = 32'h3100; req_data = 32'h55;
      step;
      req_valid = 1'b0;
      step;
      n_cmp++;
      if (wr_s !== 1'b1 || blk_addr !== 32'h3100) begin
         n_err++; $display("FAIL tmo_next_req got w%b a %h want w1 a 3100", wr_s, blk_addr);
      end
      verify = 1'b1; mesi_in = 2'b11;
      step;
      verify = 1'b0;
      step;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b0 || rsp_state !== 2'b11 || rsp_addr !== 32'h3100) begin
         n_err++; $display("FAIL tmo_next_rsp got v%b t%b st %b a %h want v1 t0 st 11 a 3100",
                           rsp_valid, rsp_timeout, rsp_state, rsp_addr);
      end
      step;
   endtask

   task automatic test_ack_hold;
      int na;
      int nv;
      req_valid = 1'b1; req_is_write = 1'b0; req_addr = 32'h4000;
      step;
      req_valid = 1'b0;
      step;
      verify = 1'b1; mesi_in = 2'b01;
      step;
      na = 0; nv = 0;
      for (int i = 0; i < 8; i++) begin
         if (ack) na++;
         if (rsp_valid) nv++;
         if (i == 2) verify = 1'b0;
         step;
      end
      n_cmp++;
      if (na !== 3) begin n_err++; $display("FAIL ack_len got %0d want 3", na); end
      n_cmp++;
      if (nv !== 1 || rsp_state !== 2'b01 || rsp_addr !== 32'h4000) begin
         n_err++; $display("FAIL ack_rsp got n%0d st %b a %h want n1 st 01 a 4000", nv, rsp_state, rsp_addr);
      end
   endtask

   task automatic test_reset_mid;
      int bad;
      req_is_write = 1'b0;
      req_valid = 1'b1; req_addr = 32'h5000;
      step;
      req_addr = 32'h5100;
      step;
      req_addr = 32'h5200;
      step;
      req_valid = 1'b0;
      verify = 1'b1; mesi_in = 2'b10;
      step;
      n_cmp++;
      if (ack !== 1'b1 || req_ready !== 1'b1) begin
         n_err++; $display("FAIL rstmid_ack got ack %b rdy %b want 1 1", ack, req_ready);
      end
      reset = 1'b1;
      step;
      reset = 1'b0; verify = 1'b0;
      n_cmp++;
      if ({rd_s, wr_s, ack, rsp_valid, rsp_timeout} !== 5'b0 || req_ready !== 1'b1 ||
          {blk_addr, local_data, rsp_addr, rsp_state} !== 98'b0) begin
         n_err++; $display("FAIL rstmid_out got ctl %b rdy %b a %h want ctl 00000 rdy 1 a 0",
                           {rd_s, wr_s, ack, rsp_valid, rsp_timeout}, req_ready, blk_addr);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (rd_s || wr_s || ack || rsp_valid) bad++;
         step;
      end
      n_cmp++;
      if (bad !== 0) begin n_err++; $display("FAIL rstmid_flush got %0d active cycles want 0", bad); end
   endtask

   initial begin
      test_reset;
      test_read;
      test_write;
      test_back_to_back;
      test_fifo_full;
      test_timeout;
      test_ack_hold;
      test_reset_mid;
      n_cmp++;
      if (viol !== 0) begin n_err++; $display("FAIL invariants got %0d violations want 0", viol); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
